// File: rtl/vref_sweep_ctrl.sv
// Receiver Vref sweep: steps every code, launches a point test per code, programs the centre of the longest all-lane-pass window.
// Latency: SETTLE_CYC + L + 2 cycles per code (L = pt_start to pt_done distance), plus one FINISH cycle before o_done.
// Backpressure: none; i_en is a level handshake, i_pt_done is honoured only in RUN_PT after the launch cycle, with a timeout fallback.
module vref_sweep_ctrl #(
  parameter int CODE_W       = 4,
  parameter int LANES        = 16,
  parameter int SETTLE_CYC   = 8,
  parameter int PT_TIMEOUT   = 1024,
  parameter int DEFAULT_CODE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_pt_done,
  input  logic [LANES-1:0]  i_lanes_result,
  output logic              o_pt_start,
  output logic [CODE_W-1:0] o_vref_code,
  output logic              o_done,
  output logic              o_cal_pass,
  output logic [CODE_W-1:0] o_pass_min,
  output logic [CODE_W-1:0] o_pass_max
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN_PT,
    S_EVAL,
    S_FINISH,
    S_DONE
  } state_t;

  localparam logic [CODE_W-1:0] CODE_MAX    = '1;
  localparam logic [CODE_W-1:0] DEF_CODE    = CODE_W'(DEFAULT_CODE);
  localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [15:0]       TO_LIMIT    = 16'(PT_TIMEOUT);

  state_t              state, state_n;
  logic [7:0]          settle_cnt, settle_cnt_n;
  logic [15:0]         to_cnt, to_cnt_n;
  logic                code_pass, code_pass_n;
  logic [CODE_W:0]     run_len, run_len_n;
  logic [CODE_W-1:0]   run_lo, run_lo_n;
  logic [CODE_W:0]     best_len, best_len_n;
  logic [CODE_W-1:0]   best_lo, best_lo_n;
  logic [CODE_W-1:0]   best_hi, best_hi_n;
  logic                pt_start_n, done_n, cal_pass_n;
  logic [CODE_W-1:0]   vref_code_n, pass_min_n, pass_max_n;

  // Window bookkeeping helpers: length of the run if this code passes, and the floored centre at CODE_W+1 bits.
  logic [CODE_W:0]     run_inc;
  logic [CODE_W:0]     bound_sum;
  logic [CODE_W-1:0]   mid_code;

  assign run_inc   = run_len + 1'b1;
  assign bound_sum = {1'b0, best_lo} + {1'b0, best_hi};
  assign mid_code  = CODE_W'(bound_sum >> 1);

  // State register; reset wins over everything including a sweep in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and next-value logic for every registered output and tracker.
  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    to_cnt_n     = to_cnt;
    code_pass_n  = code_pass;
    run_len_n    = run_len;
    run_lo_n     = run_lo;
    best_len_n   = best_len;
    best_lo_n    = best_lo;
    best_hi_n    = best_hi;
    pt_start_n   = 1'b0;
    done_n       = 1'b0;
    cal_pass_n   = o_cal_pass;
    vref_code_n  = o_vref_code;
    pass_min_n   = o_pass_min;
    pass_max_n   = o_pass_max;

    case (state)
      S_IDLE: begin
        settle_cnt_n = '0;
        run_len_n    = '0;
        best_len_n   = '0;
        // The calibrated code stays on the pins until a new sweep actually starts.
        if (i_en) begin
          state_n     = S_SETTLE;
          vref_code_n = '0;
        end
      end

      S_SETTLE: begin
        if (!i_en) begin
          state_n     = S_IDLE;
          vref_code_n = DEF_CODE;
          cal_pass_n  = 1'b0;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_n    = S_RUN_PT;
          pt_start_n = 1'b1;
          to_cnt_n   = '0;
        end else begin
          settle_cnt_n = settle_cnt + 8'd1;
        end
      end

      S_RUN_PT: begin
        // o_pt_start high marks the launch cycle, where a stale pt_done must not count.
        if (!i_en) begin
          state_n     = S_IDLE;
          vref_code_n = DEF_CODE;
          cal_pass_n  = 1'b0;
        end else if (!o_pt_start && i_pt_done) begin
          code_pass_n = &i_lanes_result;
          state_n     = S_EVAL;
        end else if (to_cnt == TO_LIMIT) begin
          code_pass_n = 1'b0;
          state_n     = S_EVAL;
        end else begin
          to_cnt_n = to_cnt + 16'd1;
        end
      end

      S_EVAL: begin
        if (!i_en) begin
          state_n     = S_IDLE;
          vref_code_n = DEF_CODE;
          cal_pass_n  = 1'b0;
        end else begin
          if (code_pass) begin
            run_len_n = run_inc;
            if (run_len == '0) run_lo_n = o_vref_code;
            // Strict compare: an equal-length later window never displaces the earlier one.
            if (run_inc > best_len) begin
              best_lo_n  = (run_len == '0) ? o_vref_code : run_lo;
              best_hi_n  = o_vref_code;
              best_len_n = run_inc;
            end
          end else begin
            run_len_n = '0;
          end
          if (o_vref_code == CODE_MAX) begin
            state_n = S_FINISH;
          end else begin
            vref_code_n  = o_vref_code + 1'b1;
            settle_cnt_n = '0;
            state_n      = S_SETTLE;
          end
        end
      end

      S_FINISH: begin
        if (!i_en) begin
          state_n     = S_IDLE;
          vref_code_n = DEF_CODE;
          cal_pass_n  = 1'b0;
        end else begin
          if (best_len != '0) begin
            vref_code_n = mid_code;
            pass_min_n  = best_lo;
            pass_max_n  = best_hi;
            cal_pass_n  = 1'b1;
          end else begin
            vref_code_n = DEF_CODE;
            pass_min_n  = '0;
            pass_max_n  = '0;
            cal_pass_n  = 1'b0;
          end
          done_n  = 1'b1;
          state_n = S_DONE;
        end
      end

      S_DONE: begin
        if (!i_en) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt  <= '0;
      to_cnt      <= '0;
      code_pass   <= 1'b0;
      run_len     <= '0;
      run_lo      <= '0;
      best_len    <= '0;
      best_lo     <= '0;
      best_hi     <= '0;
      o_pt_start  <= 1'b0;
      o_done      <= 1'b0;
      o_cal_pass  <= 1'b0;
      o_vref_code <= DEF_CODE;
      o_pass_min  <= '0;
      o_pass_max  <= '0;
    end else begin
      settle_cnt  <= settle_cnt_n;
      to_cnt      <= to_cnt_n;
      code_pass   <= code_pass_n;
      run_len     <= run_len_n;
      run_lo      <= run_lo_n;
      best_len    <= best_len_n;
      best_lo     <= best_lo_n;
      best_hi     <= best_hi_n;
      o_pt_start  <= pt_start_n;
      o_done      <= done_n;
      o_cal_pass  <= cal_pass_n;
      o_vref_code <= vref_code_n;
      o_pass_min  <= pass_min_n;
      o_pass_max  <= pass_max_n;
    end
  end

endmodule

// File: tb/tb_vref_sweep_ctrl.sv
// Directed bench for vref_sweep_ctrl: full sweeps with chosen pass masks, a withheld point test, and two abort flavours.
// Latency: point-test responder answers 3 cycles after each o_pt_start.
// Backpressure: none; each wait on the DUT is bounded by a cycle budget.
module tb_vref_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic        i_pt_done;
  logic [15:0] i_lanes_result;
  logic        o_pt_start;
  logic [3:0]  o_vref_code;
  logic        o_done;
  logic        o_cal_pass;
  logic [3:0]  o_pass_min;
  logic [3:0]  o_pass_max;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-sweep observations collected by the sweep task.
  int n_pt, n_done, first_pt, code_at1, seq_err, fin;

  vref_sweep_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (i_en),
    .i_pt_done     (i_pt_done),
    .i_lanes_result(i_lanes_result),
    .o_pt_start    (o_pt_start),
    .o_vref_code   (o_vref_code),
    .o_done        (o_done),
    .o_cal_pass    (o_cal_pass),
    .o_pass_min    (o_pass_min),
    .o_pass_max    (o_pass_max)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run one sweep from IDLE. hold: code whose point test never answers (-1 none).
  // ab_kind 0 drops i_en in SETTLE of ab_code; ab_kind 1 pulses rst in RUN_PT of ab_code.
  task automatic sweep(input logic [15:0] pmask, input int hold, input int ab_code, input int ab_kind);
    int cd, ab_left;
    cd = 0; ab_left = 0;
    n_pt = 0; n_done = 0; first_pt = -1; code_at1 = -1; seq_err = 0; fin = 0;
    i_en = 1'b1;
    for (int cyc = 1; cyc <= 6000 && fin == 0; cyc++) begin
      @(negedge clk);
      i_pt_done = 1'b0;
      if (cyc == 1) code_at1 = int'(o_vref_code);
      if (ab_left > 0) begin
        ab_left--;
        rst = 1'b0;
        if (o_done) n_done++;
        if (ab_left == 0) fin = 1;
      end else if (o_done) begin
        n_done++;
        fin = 1;
      end else if (o_pt_start) begin
        if (n_pt == 0) first_pt = cyc;
        if (int'(o_vref_code) != n_pt) seq_err++;
        n_pt++;
        if (int'(o_vref_code) != hold) cd = 3;
        if (ab_kind == 1 && int'(o_vref_code) == ab_code) begin
          rst = 1'b1; i_en = 1'b0; ab_left = 2; cd = 0;
        end
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            i_pt_done = 1'b1;
            i_lanes_result = pmask[o_vref_code] ? 16'hFFFF : 16'hFFDF;
          end
        end
        if (ab_kind == 0 && i_en && int'(o_vref_code) == ab_code) begin
          i_en = 1'b0; ab_left = 2;
        end
      end
    end
    check("sweep_terminated", fin, 1);
  endtask

  // Results of a completed sweep, then the one-cycle shape of o_done, then release i_en.
  task automatic expect_done(input string tag, input int ecode, input int emin, input int emax, input int ecal);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_pt_count"}, n_pt, 16);
    check({tag, "_code_order"}, seq_err, 0);
    check({tag, "_first_code"}, code_at1, 0);
    check({tag, "_first_pt_cycle"}, first_pt, 9);
    check({tag, "_vref_code"}, o_vref_code, ecode);
    check({tag, "_pass_min"}, o_pass_min, emin);
    check({tag, "_pass_max"}, o_pass_max, emax);
    check({tag, "_cal_pass"}, o_cal_pass, ecal);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, o_done, 0);
    check({tag, "_held_code"}, o_vref_code, ecode);
    i_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; i_en = 1'b0; i_pt_done = 1'b0; i_lanes_result = '0;
    repeat (3) @(negedge clk);
    check("reset_code", o_vref_code, 8);
    check("reset_pt_start", o_pt_start, 0);
    check("reset_done", o_done, 0);
    check("reset_cal_pass", o_cal_pass, 0);
    check("reset_pass_min", o_pass_min, 0);
    check("reset_pass_max", o_pass_max, 0);
    rst = 1'b0;
    @(negedge clk);

    // Every code passes: window 0..15, centre 7.
    sweep(16'hFFFF, -1, -1, 2);
    expect_done("all_pass", 7, 0, 15, 1);

    // Passing codes 3..9 and 12..13: longest window 3..9, centre 6, retained in IDLE.
    sweep(16'h33F8, -1, -1, 2);
    expect_done("window", 6, 3, 9, 1);
    repeat (3) @(negedge clk);
    check("idle_keeps_code", o_vref_code, 6);
    check("idle_keeps_cal_pass", o_cal_pass, 1);

    // Tied windows 2..4 and 10..12: earliest kept, centre 3.
    sweep(16'h1C1C, -1, -1, 2);
    expect_done("tie", 3, 2, 4, 1);

    // Nothing passes: default code, no window.
    sweep(16'h0000, -1, -1, 2);
    expect_done("none", 8, 0, 0, 0);

    // Point test at code 5 never answers: timeout fails it, window 6..15, centre 10.
    sweep(16'hFFFF, 5, -1, 2);
    expect_done("timeout", 10, 6, 15, 1);

    // Drop i_en in SETTLE of code 4 after a passing sweep.
    sweep(16'hFFFF, -1, 4, 0);
    check("abort_en_no_done", n_done, 0);
    check("abort_en_pt_count", n_pt, 4);
    check("abort_en_code", o_vref_code, 8);
    check("abort_en_cal_pass", o_cal_pass, 0);
    check("abort_en_pt_start", o_pt_start, 0);

    // Restart from code 0 after the abort.
    sweep(16'hFFFF, -1, -1, 2);
    expect_done("restart", 7, 0, 15, 1);

    // Reset in RUN_PT of code 2.
    sweep(16'hFFFF, -1, 2, 1);
    check("abort_rst_no_done", n_done, 0);
    check("abort_rst_pt_count", n_pt, 3);
    check("abort_rst_code", o_vref_code, 8);
    check("abort_rst_cal_pass", o_cal_pass, 0);
    check("abort_rst_pass_min", o_pass_min, 0);
    check("abort_rst_pass_max", o_pass_max, 0);
    repeat (4) @(negedge clk);
    check("abort_rst_idle_quiet", o_pt_start, 0);

    // Fresh sweep after reset still finds the right window.
    sweep(16'h33F8, -1, -1, 2);
    expect_done("post_reset", 6, 3, 9, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
